// File: rtl/uart_px.sv
// uart_px: UART with a runtime baud divisor, 5-8 data bits, optional parity, 1/2 stop bits.
// Includes the small first-word-fall-through FIFO used for both the TX and RX queues.

module uart_px_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO survives only when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module uart_px #(
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       cfg_dbits,
    input  logic [1:0]       cfg_par,
    input  logic             cfg_stop2,
    input  logic             tx_wr,
    input  logic [7:0]       tx_din,
    output logic             tx_full,
    output logic             tx_busy,
    output logic             ser_txd,
    input  logic             ser_rxd,
    input  logic             rx_rd,
    output logic [7:0]       rx_dout,
    output logic             rx_empty,
    input  logic             err_clr,
    output logic             rx_err_frame,
    output logic             rx_err_par,
    output logic             rx_overrun
);
    typedef enum logic [2:0] {
        TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HI
    } rx_state_t;

    logic [DIV_W-1:0] div_eff;
    assign div_eff = (baud_div < DIV_W'(3)) ? DIV_W'(3) : baud_div;

    // ---------------- TX ----------------
    logic       tx_pop;
    logic       tx_empty;
    logic [7:0] tx_head;

    uart_px_fifo #(.AW(FIFO_AW), .W(8)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_wr), .din(tx_din), .pop(tx_pop),
        .head(tx_head), .empty(tx_empty), .full(tx_full)
    );

    tx_state_t        tx_state, tx_state_nx;
    logic [DIV_W-1:0] tx_cnt, tx_cnt_nx, tx_div, tx_div_nx;
    logic [2:0]       tx_bit, tx_bit_nx, tx_last, tx_last_nx;
    logic [7:0]       tx_sh, tx_sh_nx;
    logic             txd, txd_nx;
    logic             tx_par_acc, tx_par_acc_nx;
    logic             tx_par_en, tx_par_en_nx, tx_par_odd, tx_par_odd_nx;
    logic             tx_stop2, tx_stop2_nx;
    logic             tx_load;
    logic             tx_bit_end;
    logic             tx_last_stop;

    assign tx_bit_end   = (tx_cnt == tx_div);
    assign tx_last_stop = (tx_state == TX_STOP2) || ((tx_state == TX_STOP1) && !tx_stop2);

    always_comb begin
        tx_state_nx   = tx_state;
        tx_cnt_nx     = tx_cnt;
        tx_bit_nx     = tx_bit;
        tx_sh_nx      = tx_sh;
        txd_nx        = txd;
        tx_par_acc_nx = tx_par_acc;
        tx_div_nx     = tx_div;
        tx_last_nx    = tx_last;
        tx_par_en_nx  = tx_par_en;
        tx_par_odd_nx = tx_par_odd;
        tx_stop2_nx   = tx_stop2;
        tx_pop        = 1'b0;
        tx_load       = 1'b0;

        if (tx_state != TX_IDLE && tx_state != TX_LOAD)
            tx_cnt_nx = tx_bit_end ? '0 : tx_cnt + DIV_W'(1);

        case (tx_state)
            TX_IDLE: begin
                txd_nx = 1'b1;
                if (!tx_empty) tx_load = 1'b1;
            end
            TX_LOAD: begin
                tx_state_nx = TX_START;
                tx_cnt_nx   = '0;
                txd_nx      = 1'b0;
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_nx   = TX_DATA;
                    tx_bit_nx     = '0;
                    txd_nx        = tx_sh[0];
                    tx_par_acc_nx = tx_sh[0];
                    tx_sh_nx      = tx_sh >> 1;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit == tx_last) begin
                        tx_state_nx = tx_par_en ? TX_PAR : TX_STOP1;
                        txd_nx      = tx_par_en ? (tx_par_acc ^ tx_par_odd) : 1'b1;
                    end else begin
                        tx_bit_nx     = tx_bit + 3'd1;
                        txd_nx        = tx_sh[0];
                        tx_par_acc_nx = tx_par_acc ^ tx_sh[0];
                        tx_sh_nx      = tx_sh >> 1;
                    end
                end
            end
            TX_PAR: begin
                if (tx_bit_end) begin
                    tx_state_nx = TX_STOP1;
                    txd_nx      = 1'b1;
                end
            end
            TX_STOP1, TX_STOP2: begin
                // Popping one clock early lets the LOAD cycle stand in for the last stop clock.
                if (tx_last_stop) begin
                    if (!tx_empty && ((tx_cnt == tx_div - DIV_W'(1)) || tx_bit_end))
                        tx_load = 1'b1;
                    else if (tx_bit_end)
                        tx_state_nx = TX_IDLE;
                end else if (tx_bit_end) begin
                    tx_state_nx = TX_STOP2;
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase

        if (tx_load) begin
            tx_pop        = 1'b1;
            tx_state_nx   = TX_LOAD;
            tx_sh_nx      = tx_head;
            tx_div_nx     = div_eff;
            tx_last_nx    = {1'b1, cfg_dbits};
            tx_par_en_nx  = cfg_par[1];
            tx_par_odd_nx = cfg_par[0];
            tx_stop2_nx   = cfg_stop2;
            tx_par_acc_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            txd      <= txd_nx;
        end
    end

    always_ff @(posedge clk) begin
        tx_sh      <= tx_sh_nx;
        tx_par_acc <= tx_par_acc_nx;
        tx_div     <= tx_div_nx;
        tx_last    <= tx_last_nx;
        tx_par_en  <= tx_par_en_nx;
        tx_par_odd <= tx_par_odd_nx;
        tx_stop2   <= tx_stop2_nx;
    end

    assign ser_txd = txd;
    assign tx_busy = !tx_empty || (tx_state != TX_IDLE);

    // ---------------- RX ----------------
    logic rx_s1, rx_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= ser_rxd;
            rx_s2 <= rx_s1;
        end
    end

    rx_state_t        rx_state, rx_state_nx;
    logic [DIV_W-1:0] rx_cnt, rx_cnt_nx, rx_div, rx_div_nx;
    logic [2:0]       rx_bit, rx_bit_nx, rx_last, rx_last_nx;
    logic [1:0]       rx_dbits, rx_dbits_nx;
    logic [7:0]       rx_sh, rx_sh_nx;
    logic             rx_par_acc, rx_par_acc_nx, rx_par_bad, rx_par_bad_nx;
    logic             rx_par_en, rx_par_en_nx, rx_par_odd, rx_par_odd_nx;
    logic             rx_push, rx_full, rx_mid;
    logic             set_frame, set_par, set_ovr;
    logic [7:0]       rx_byte, rx_head;

    assign rx_mid  = (rx_cnt == rx_div);
    // Bits arrive at the top of the shifter; shift down so the word is right-aligned.
    assign rx_byte = rx_sh >> (2'd3 - rx_dbits);

    always_comb begin
        rx_state_nx   = rx_state;
        rx_cnt_nx     = rx_cnt;
        rx_bit_nx     = rx_bit;
        rx_sh_nx      = rx_sh;
        rx_par_acc_nx = rx_par_acc;
        rx_par_bad_nx = rx_par_bad;
        rx_div_nx     = rx_div;
        rx_last_nx    = rx_last;
        rx_dbits_nx   = rx_dbits;
        rx_par_en_nx  = rx_par_en;
        rx_par_odd_nx = rx_par_odd;
        rx_push       = 1'b0;
        set_frame     = 1'b0;
        set_par       = 1'b0;
        set_ovr       = 1'b0;

        if (rx_state != RX_IDLE && rx_state != RX_WAIT_HI)
            rx_cnt_nx = rx_cnt + DIV_W'(1);

        case (rx_state)
            RX_IDLE: begin
                if (!rx_s2) begin
                    rx_state_nx = RX_START;
                    rx_cnt_nx   = '0;
                    rx_bit_nx   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt >= (div_eff >> 1)) begin
                    if (rx_s2) begin
                        rx_state_nx = RX_IDLE;
                    end else begin
                        rx_state_nx   = RX_DATA;
                        rx_cnt_nx     = '0;
                        rx_div_nx     = div_eff;
                        rx_last_nx    = {1'b1, cfg_dbits};
                        rx_dbits_nx   = cfg_dbits;
                        rx_par_en_nx  = cfg_par[1];
                        rx_par_odd_nx = cfg_par[0];
                        rx_sh_nx      = '0;
                        rx_par_acc_nx = 1'b0;
                        rx_par_bad_nx = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_mid) begin
                    rx_cnt_nx     = '0;
                    rx_sh_nx      = {rx_s2, rx_sh[7:1]};
                    rx_par_acc_nx = rx_par_acc ^ rx_s2;
                    if (rx_bit == rx_last)
                        rx_state_nx = rx_par_en ? RX_PAR : RX_STOP;
                    else
                        rx_bit_nx = rx_bit + 3'd1;
                end
            end
            RX_PAR: begin
                if (rx_mid) begin
                    rx_cnt_nx     = '0;
                    rx_par_bad_nx = rx_s2 ^ rx_par_acc ^ rx_par_odd;
                    rx_state_nx   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_mid) begin
                    rx_push     = 1'b1;
                    set_frame   = !rx_s2;
                    set_par     = rx_par_en && rx_par_bad;
                    set_ovr     = rx_full && !rx_rd;
                    rx_state_nx = rx_s2 ? RX_IDLE : RX_WAIT_HI;
                end
            end
            RX_WAIT_HI: begin
                if (rx_s2) rx_state_nx = RX_IDLE;
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
        end
    end

    always_ff @(posedge clk) begin
        rx_sh      <= rx_sh_nx;
        rx_par_acc <= rx_par_acc_nx;
        rx_par_bad <= rx_par_bad_nx;
        rx_div     <= rx_div_nx;
        rx_last    <= rx_last_nx;
        rx_dbits   <= rx_dbits_nx;
        rx_par_en  <= rx_par_en_nx;
        rx_par_odd <= rx_par_odd_nx;
    end

    uart_px_fifo #(.AW(FIFO_AW), .W(8)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .din(rx_byte), .pop(rx_rd),
        .head(rx_head), .empty(rx_empty), .full(rx_full)
    );

    assign rx_dout = rx_empty ? 8'h00 : rx_head;

    // A set event in the same cycle as err_clr takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_err_frame <= 1'b0;
            rx_err_par   <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            if (set_frame)    rx_err_frame <= 1'b1;
            else if (err_clr) rx_err_frame <= 1'b0;
            if (set_par)      rx_err_par   <= 1'b1;
            else if (err_clr) rx_err_par   <= 1'b0;
            if (set_ovr)      rx_overrun   <= 1'b1;
            else if (err_clr) rx_overrun   <= 1'b0;
        end
    end
endmodule
